instr_decode_stage: RTL
=======================

# instr_decode_stage

Registered, flow-controlled instruction decode stage with a parametrised output queue. It sits between fetch and execute in the processor. It accepts raw 32-bit instruction words with their PC over a valid/ready handshake and decodes each into an instruction ID and three XLEN-wide operands, flagging illegal encodings. Results are buffered so execute stalls do not immediately back-pressure fetch.

## Interface
- XLEN, 32: operand/PC width; must be ≥ 32.
- DEPTH, 2: output queue entries; power of two, ≥ 2.
- ZEXT_LOGIC, 1: 1 = andi/ori immediates zero-extended; 0 = sign-extended.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- flush  in  1  synchronous discard of all queued entries.
- in_valid  in  1  instruction word present.
- in_ready  out  1  stage can accept.
- in_ir  in  32  instruction word.
- in_pc  in  XLEN  PC of the instruction.
- out_valid  out  1  head entry valid.
- out_ready  in  1  consumer takes head.
- out_id  out  32  instruction ID (0 when illegal).
- out_rs, out_rt, out_rd  out  XLEN  decoded operands.
- out_pc  out  XLEN  PC passthrough.
- out_illegal  out  1  head entry is an illegal encoding.
- illegal_cnt  out  16  saturating count of illegal instructions accepted.

## Operation
- Decoding uses op = ir[31:26] and fn = ir[5:0].
  - op 0, fn 0..3: ID = fn+1 (add/sub/addu/subu). R-format.
  - op 1..6: ID = op+4. Op 3 and 4 are R-format and require fn = 0. Others are I-format.
  - op 7, fn 0..1: ID = fn+11 (sll/srl). I-format.
  - op 8..15 and op 20: ID = op+5. I-format.
  - op 16, 18 (j, jal): ID = op+5. out_rs = zero-extended ir[25:0].
  - op 17 (jr): ID 22. out_rs = ir[25:21].
  - op 19 (slt): ID 24. R-format, fn must be 0.
  - op 21 (syscall), fn 0..1: ID = 27+fn (display/exit).
  - Any other op/fn combination is illegal: ID 0, out_illegal = 1, all operands 0.
- Operand formats:
  - R-format: rs = ir[25:21], rt = ir[20:16], rd = ir[15:11], all zero-extended.
  - I-format: rs = ir[25:21], rd = ir[20:16], rt = imm16 extended.
  - Imm16 is sign-extended to XLEN, except andi/ori, which zero-extend when ZEXT_LOGIC = 1.
- Any operand field unused by an instruction is driven 0, never left holding a previous value.
- Decode is combinational. The decoded record {id, rs, rt, rd, pc, illegal} is pushed into the queue on in_valid && in_ready.
- Queue behaviour:
  - in_ready = (count < DEPTH). It does not depend on out_ready, so there is no same-cycle pass-through when full.
  - out_valid = (count != 0).
  - Output ports show the head entry, or all-zero when empty.
  - Push and pop in the same cycle leave count unchanged. Read and write pointers wrap modulo DEPTH.
- flush takes priority over push and pop: count ← 0, pointers ← 0, and the word offered that cycle is dropped. illegal_cnt is unaffected by flush.
- illegal_cnt increments on each accepted illegal word and saturates at 0xFFFF.

## Timing
- Reset (async assert, sync-safe deassert handled upstream): count, pointers and illegal_cnt = 0. out_valid = 0, in_ready = 1, all out_* data = 0.
- Latency: a word accepted at edge k is visible on out_* with out_valid = 1 after edge k.
- Throughput: one instruction per cycle while out_ready is held high.
- Empty with push: out_valid rises the next cycle.
- Full with pop: in_ready rises the next cycle.
- Reset asserted mid-operation discards all entries immediately.

## Structure
- Shared package decode_pkg holds:
  - opcode and function localparams;
  - instruction ID constants (1..28);
  - decoded-record struct type parametrised on XLEN via typedef in the consumer.
- The single sub-module is decode_fifo: a generic synchronous queue with width, depth, flush, and count. The decode logic is an always_comb block in the top module.

## Test plan
- in_ir = 0x00221800 (add r3,r1,r2), out_ready = 1 → next cycle out_id = 1, rs = 1, rt = 2, rd = 3, out_illegal = 0.
- in_ir = 0x0425FFFC (addi r5,r1,-4) → out_id = 5, rs = 1, rt = 0xFFFFFFFC, rd = 5.
- in_ir = 0x14228000 (andi r2,r1,0x8000):
  - ZEXT_LOGIC = 1 → rt = 0x00008000, id = 9.
  - ZEXT_LOGIC = 0 → rt = 0xFFFF8000.
- in_ir = 0x40000064 (j 100) → id = 21, rs = 100, rt = rd = 0. Then in_ir = 0x58000000 (op 22) → id = 0, out_illegal = 1, illegal_cnt = 1.
- Hold out_ready = 0 and push 3 words with DEPTH = 2:
  - in_ready drops after the 2nd word and the 3rd is held.
  - Raising out_ready drains the entries in order.
  - No loss or duplication across pointer wrap.
- Queue holding 2 entries with flush and in_valid high in the same cycle → next cycle out_valid = 0, count = 0, and the offered word is absent. Async rst_n low mid-stream → all outputs 0 immediately.

Source files
------------

// File: rtl/decode_pkg.sv
// Opcode/function encodings, instruction IDs and operand-format tags shared by the decode stage.
package decode_pkg;

    localparam logic [5:0] OP_RTYPE   = 6'd0;
    localparam logic [5:0] OP_ADDI    = 6'd1;
    localparam logic [5:0] OP_SUBI    = 6'd2;
    localparam logic [5:0] OP_MUL     = 6'd3;
    localparam logic [5:0] OP_DIV     = 6'd4;
    localparam logic [5:0] OP_ANDI    = 6'd5;
    localparam logic [5:0] OP_ORI     = 6'd6;
    localparam logic [5:0] OP_SHIFT   = 6'd7;
    localparam logic [5:0] OP_J       = 6'd16;
    localparam logic [5:0] OP_JR      = 6'd17;
    localparam logic [5:0] OP_JAL     = 6'd18;
    localparam logic [5:0] OP_SLT     = 6'd19;
    localparam logic [5:0] OP_IMM20   = 6'd20;
    localparam logic [5:0] OP_SYSCALL = 6'd21;

    localparam logic [5:0] FN_NONE    = 6'd0;
    localparam logic [5:0] FN_SUBU    = 6'd3;
    localparam logic [5:0] FN_SRL     = 6'd1;
    localparam logic [5:0] FN_EXIT    = 6'd1;

    localparam logic [31:0] ID_ILLEGAL = 32'd0;
    localparam logic [31:0] ID_ADD     = 32'd1;
    localparam logic [31:0] ID_SUB     = 32'd2;
    localparam logic [31:0] ID_ADDU    = 32'd3;
    localparam logic [31:0] ID_SUBU    = 32'd4;
    localparam logic [31:0] ID_ADDI    = 32'd5;
    localparam logic [31:0] ID_ANDI    = 32'd9;
    localparam logic [31:0] ID_ORI     = 32'd10;
    localparam logic [31:0] ID_SLL     = 32'd11;
    localparam logic [31:0] ID_SRL     = 32'd12;
    localparam logic [31:0] ID_J       = 32'd21;
    localparam logic [31:0] ID_JR      = 32'd22;
    localparam logic [31:0] ID_JAL     = 32'd23;
    localparam logic [31:0] ID_SLT     = 32'd24;
    localparam logic [31:0] ID_DISPLAY = 32'd27;
    localparam logic [31:0] ID_EXIT    = 32'd28;

    // ID = opcode + offset for the opcode-only families
    localparam logic [31:0] OP_ID_OFS_LO = 32'd4;
    localparam logic [31:0] OP_ID_OFS_HI = 32'd5;

    typedef enum logic [2:0] {
        FMT_ILL,
        FMT_R,
        FMT_I,
        FMT_J,
        FMT_JR,
        FMT_SYS
    } fmt_e;

    function automatic logic is_logic_imm(input logic [5:0] op);
        return (op == OP_ANDI) || (op == OP_ORI);
    endfunction

endpackage

// File: rtl/decode_fifo.sv
// Generic synchronous queue with occupancy count and a flush that clears it in one cycle.
module decode_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           wdata_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop, empty;

    assign empty   = (count_q == '0);
    assign do_push = push_i && (count_q != CW'(DEPTH)) && !flush_i;
    assign do_pop  = pop_i && !empty && !flush_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the head is masked to zero whenever the queue is empty
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = empty ? '0 : mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/instr_decode_stage.sv
// Combinational instruction decode feeding a small output queue between fetch and execute.
module instr_decode_stage
    import decode_pkg::*;
#(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned DEPTH      = 2,
    parameter int unsigned ZEXT_LOGIC = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_ir,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_id,
    output logic [XLEN-1:0] out_rs,
    output logic [XLEN-1:0] out_rt,
    output logic [XLEN-1:0] out_rd,
    output logic [XLEN-1:0] out_pc,
    output logic            out_illegal,
    output logic [15:0]     illegal_cnt
);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [31:0]     id;
        logic [XLEN-1:0] rs;
        logic [XLEN-1:0] rt;
        logic [XLEN-1:0] rd;
        logic [XLEN-1:0] pc;
        logic            illegal;
    } dec_rec_t;

    logic [5:0]      op, fn;
    fmt_e            fmt;
    logic [31:0]     dec_id;
    logic [XLEN-1:0] imm_ext;
    dec_rec_t        rec, head;
    logic [CW-1:0]   count;
    logic            accept;
    logic [15:0]     illegal_cnt_q, illegal_cnt_d;

    assign op = in_ir[31:26];
    assign fn = in_ir[5:0];

    always_comb begin
        fmt    = FMT_ILL;
        dec_id = ID_ILLEGAL;
        case (op)
            OP_RTYPE: if (fn <= FN_SUBU) begin
                fmt    = FMT_R;
                dec_id = ID_ADD + 32'(fn);
            end
            OP_ADDI, OP_SUBI, OP_ANDI, OP_ORI: begin
                fmt    = FMT_I;
                dec_id = 32'(op) + OP_ID_OFS_LO;
            end
            OP_MUL, OP_DIV: if (fn == FN_NONE) begin
                fmt    = FMT_R;
                dec_id = 32'(op) + OP_ID_OFS_LO;
            end
            OP_SHIFT: if (fn <= FN_SRL) begin
                fmt    = FMT_I;
                dec_id = ID_SLL + 32'(fn);
            end
            6'd8, 6'd9, 6'd10, 6'd11, 6'd12, 6'd13, 6'd14, 6'd15, OP_IMM20: begin
                fmt    = FMT_I;
                dec_id = 32'(op) + OP_ID_OFS_HI;
            end
            OP_J, OP_JAL: begin
                fmt    = FMT_J;
                dec_id = 32'(op) + OP_ID_OFS_HI;
            end
            OP_JR: begin
                fmt    = FMT_JR;
                dec_id = ID_JR;
            end
            OP_SLT: if (fn == FN_NONE) begin
                fmt    = FMT_R;
                dec_id = ID_SLT;
            end
            OP_SYSCALL: if (fn <= FN_EXIT) begin
                fmt    = FMT_SYS;
                dec_id = ID_DISPLAY + 32'(fn);
            end
            default: begin
                fmt    = FMT_ILL;
                dec_id = ID_ILLEGAL;
            end
        endcase
    end

    assign imm_ext = ((ZEXT_LOGIC != 0) && is_logic_imm(op))
                   ? {{(XLEN-16){1'b0}}, in_ir[15:0]}
                   : {{(XLEN-16){in_ir[15]}}, in_ir[15:0]};

    always_comb begin
        rec    = '0;
        rec.id = dec_id;
        rec.pc = in_pc;
        case (fmt)
            FMT_R: begin
                rec.rs = XLEN'(in_ir[25:21]);
                rec.rt = XLEN'(in_ir[20:16]);
                rec.rd = XLEN'(in_ir[15:11]);
            end
            FMT_I: begin
                rec.rs = XLEN'(in_ir[25:21]);
                rec.rd = XLEN'(in_ir[20:16]);
                rec.rt = imm_ext;
            end
            FMT_J:   rec.rs = XLEN'(in_ir[25:0]);
            FMT_JR:  rec.rs = XLEN'(in_ir[25:21]);
            FMT_SYS: rec.rs = '0;
            default: rec.illegal = 1'b1;
        endcase
    end

    assign in_ready  = (count < CW'(DEPTH));
    assign out_valid = (count != '0);
    assign accept    = in_valid && in_ready && !flush;

    decode_fifo #(
        .WIDTH($bits(dec_rec_t)),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .flush_i(flush),
        .push_i (in_valid && in_ready),
        .wdata_i(rec),
        .pop_i  (out_ready),
        .rdata_o(head),
        .count_o(count)
    );

    always_comb begin
        illegal_cnt_d = illegal_cnt_q;
        if (accept && rec.illegal && (illegal_cnt_q != '1))
            illegal_cnt_d = illegal_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) illegal_cnt_q <= '0;
        else        illegal_cnt_q <= illegal_cnt_d;
    end

    assign out_id      = head.id;
    assign out_rs      = head.rs;
    assign out_rt      = head.rt;
    assign out_rd      = head.rd;
    assign out_pc      = head.pc;
    assign out_illegal = head.illegal;
    assign illegal_cnt = illegal_cnt_q;

endmodule
